// File: rtl/fifo_match_queue_pkg.sv
// Shared helpers for fifo_match_queue: pointer wrap, age index and count width.
// Optional feature macro: FIFO_MATCH_FWD_EN (youngest-match data forwarding).
package fifo_match_queue_pkg;

    // Combined push/pop operation of one cycle, ordered as {push, pop}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Occupancy counter must hold DEPTH itself, hence one bit more than a pointer
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Explicit compare-and-wrap so non-power-of-two depths never exceed DEPTH-1
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    // Distance of slot idx from the oldest slot (tail); larger means younger
    function automatic int unsigned age_index(input int unsigned idx, input int unsigned tail,
                                              input int unsigned depth);
        return (idx >= tail) ? idx - tail : idx + depth - tail;
    endfunction

endpackage

// File: rtl/fifo_match_queue_if.sv
// Bus bundle for fifo_match_queue: push/pop handshakes, status and lookup ports.
//
// Handshake rules: a push transfers on a rising edge where in_valid && in_ready,
// a pop transfers on a rising edge where out_valid && out_ready. in_ready and
// out_valid depend only on registered state, never on in_valid/out_ready, and
// out_data is stable while out_valid is high and no pop transfers.
interface fifo_match_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int KEY_WIDTH  = 32,
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_PORTS  = 2
);
    logic                            flush;
    logic                            in_valid;
    logic                            in_ready;
    logic [DATA_WIDTH-1:0]           in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [DATA_WIDTH-1:0]           out_data;
    logic [ADDR_WIDTH:0]             count;
    logic                            full;
    logic                            empty;
    logic [NUM_PORTS*KEY_WIDTH-1:0]  lk_key;
    logic [NUM_PORTS-1:0]            lk_hit;
    logic [NUM_PORTS*DATA_WIDTH-1:0] lk_data;

    modport master (
        output flush, in_valid, in_data, out_ready, lk_key,
        input  in_ready, out_valid, out_data, count, full, empty, lk_hit, lk_data
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready, lk_key,
        output in_ready, out_valid, out_data, count, full, empty, lk_hit, lk_data
    );
endinterface

// File: rtl/fifo_match_queue_slot.sv
// One FIFO entry: payload register, valid bit and one key comparator per lookup port.
// Storage is zeroed whenever the entry dies so stale data never reaches out_data.
module fifo_match_queue_slot #(
    parameter int DATA_WIDTH = 32,
    parameter int KEY_WIDTH  = 32,
    parameter int NUM_PORTS  = 2
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           clr,
    input  logic                           wr_en,
    input  logic                           rd_en,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [NUM_PORTS*KEY_WIDTH-1:0] lk_key,
    output logic [DATA_WIDTH-1:0]          slot_data,
    output logic [NUM_PORTS-1:0]           slot_hit
);

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    // Entry register: flush beats write, write beats read (never the same slot together)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (clr) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (wr_en) begin
            data_q  <= wr_data;
            valid_q <= 1'b1;
        end else if (rd_en) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end
    end

    // Per-port key compare, gated by valid so zeroed storage never matches key 0
    always_comb begin
        slot_hit = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            slot_hit[p] = valid_q && (data_q[KEY_WIDTH-1:0] == lk_key[p*KEY_WIDTH +: KEY_WIDTH]);
        end
    end

    assign slot_data = data_q;

endmodule

// File: rtl/fifo_match_queue.sv
// FIFO with associative lookup ports, used to track outstanding stores for
// read-after-write hazard checks between the LSU and the AXI bridge.
// Optional feature macro: FIFO_MATCH_FWD_EN -- when defined, lk_data returns the
// youngest matching entry per port; otherwise lk_data is tied to zero.
module fifo_match_queue
    import fifo_match_queue_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEY_WIDTH  = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_PORTS  = 2
) (
    input  logic               clk,
    input  logic               resetn,
    fifo_match_queue_if.slave  bus
);

    localparam int CW = count_width(ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0]       head;
    logic [ADDR_WIDTH-1:0]       tail;
    logic [CW-1:0]               count_q;
    logic                        full;
    logic                        empty;
    logic                        push;
    logic                        pop;
    fifo_op_e                    op;

    logic [DATA_WIDTH-1:0]       slot_data [DEPTH];
    logic [NUM_PORTS-1:0]        slot_hit  [DEPTH];
    logic [NUM_PORTS-1:0]        hit_vec;
    logic [NUM_PORTS*DATA_WIDTH-1:0] fwd_data;

    // Status and handshake qualification, all from registered state
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.in_valid  && !full;
    assign pop   = bus.out_ready && !empty;
    assign op    = fifo_op_e'({push, pop});

    // Pointer and occupancy registers; flush overrides any push/pop of the cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                head <= ADDR_WIDTH'(ptr_inc(32'(head), DEPTH));
            end
            if (pop) begin
                tail <= ADDR_WIDTH'(ptr_inc(32'(tail), DEPTH));
            end
            case (op)
                OP_PUSH: count_q <= count_q + CW'(1);
                OP_POP:  count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage, one slot per FIFO position
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        fifo_match_queue_slot #(
            .DATA_WIDTH (DATA_WIDTH),
            .KEY_WIDTH  (KEY_WIDTH),
            .NUM_PORTS  (NUM_PORTS)
        ) u_slot (
            .clk       (clk),
            .resetn    (resetn),
            .clr       (bus.flush),
            .wr_en     (push && (head == ADDR_WIDTH'(i))),
            .rd_en     (pop  && (tail == ADDR_WIDTH'(i))),
            .wr_data   (bus.in_data),
            .lk_key    (bus.lk_key),
            .slot_data (slot_data[i]),
            .slot_hit  (slot_hit[i])
        );
    end

    // Per-port hit: OR of every slot's comparator (an entry popping this cycle still counts)
    always_comb begin
        hit_vec = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                hit_vec[p] = hit_vec[p] | slot_hit[i][p];
            end
        end
    end

`ifdef FIFO_MATCH_FWD_EN
    // Youngest-match select: the hitting slot with the largest age from tail wins
    always_comb begin : p_fwd_select
        int   best_age;
        int   age;
        logic found;
        fwd_data = '0;
        best_age = 0;
        age      = 0;
        found    = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            best_age = 0;
            found    = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                age = int'(age_index(32'(i), 32'(tail), DEPTH));
                if (slot_hit[i][p] && (!found || age > best_age)) begin
                    found    = 1'b1;
                    best_age = age;
                    fwd_data[p*DATA_WIDTH +: DATA_WIDTH] = slot_data[i];
                end
            end
        end
    end
`else
    assign fwd_data = '0;
`endif

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : slot_data[tail];
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.lk_hit    = hit_vec;
    assign bus.lk_data   = fwd_data;

endmodule
